// File: rtl/fir_coef_axil_regs.sv
// AXI4-Lite register block holding shadow and active FIR coefficients h0..h3 with atomic commit.
// Optional FIR_SAMPLE_CNT_EN adds a 32-bit FIR output-sample counter at 0x18.
module fir_coef_axil_regs #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] COEF_RST = 16'h2000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        s_axil_awaddr,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [31:0]              s_axil_wdata,
    input  logic [3:0]               s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [ADDR_W-1:0]        s_axil_araddr,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    input  logic                     fir_valid_out,
    output logic signed [DATA_W-1:0] h0,
    output logic signed [DATA_W-1:0] h1,
    output logic signed [DATA_W-1:0] h2,
    output logic signed [DATA_W-1:0] h3
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef FIR_SAMPLE_CNT_EN
    localparam logic [2:0] MAX_IDX = 3'd6;
`else
    localparam logic [2:0] MAX_IDX = 3'd5;
`endif

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[ADDR_W-1:5] == {(ADDR_W-5){1'b0}}) && (a[4:2] <= MAX_IDX);
    endfunction

    function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [1:0]        strb);
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int i = 0; i < DATA_W; i++) begin
            if (strb[i/8]) res[i] = new_v[i];
        end
        return res;
    endfunction

    logic              aw_ready_r, w_ready_r, bvalid_r, rvalid_r;
    logic [1:0]        bresp_r, rresp_r;
    logic [31:0]       rdata_r;
    logic [ADDR_W-1:0] awaddr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [1:0]        wstrb_r;
    logic [DATA_W-1:0] shadow_r [4];
    logic [DATA_W-1:0] coef_r [4];
    logic              auto_r, pending_r;
    logic              wr_fire_s, wr_ok_s;
    logic [2:0]        wr_idx_s;
    logic [1:0]        wr_sel_s;
    logic [DATA_W-1:0] wr_merged_s;
    logic [31:0]       rd_data_s;
    logic [2:0]        rd_idx_s;
    logic [1:0]        rd_sel_s;
    logic              unused_s;
`ifdef FIR_SAMPLE_CNT_EN
    logic [31:0]       sample_cnt_r;
`endif

    // A write commits only once both address and data are held and no response is outstanding
    always_comb begin
        wr_fire_s   = !aw_ready_r && !w_ready_r && !bvalid_r;
        wr_ok_s     = addr_ok(awaddr_r);
        wr_idx_s    = awaddr_r[4:2];
        wr_sel_s    = wr_idx_s[1:0] - 2'd1;
        wr_merged_s = strb_merge(shadow_r[wr_sel_s], wdata_r, wstrb_r);
    end

    // AW/W capture and B response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_ready_r <= 1'b1;
            w_ready_r  <= 1'b1;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            awaddr_r   <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            wstrb_r    <= 2'b00;
        end else begin
            if (aw_ready_r && s_axil_awvalid) begin
                awaddr_r   <= s_axil_awaddr;
                aw_ready_r <= 1'b0;
            end
            if (w_ready_r && s_axil_wvalid) begin
                wdata_r   <= s_axil_wdata[DATA_W-1:0];
                wstrb_r   <= s_axil_wstrb[1:0];
                w_ready_r <= 1'b0;
            end
            if (wr_fire_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_r && s_axil_bready) begin
                bvalid_r   <= 1'b0;
                aw_ready_r <= 1'b1;
                w_ready_r  <= 1'b1;
            end
        end
    end

    // Shadow/active coefficient registers, AUTO and PENDING flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                shadow_r[k] <= COEF_RST;
                coef_r[k]   <= COEF_RST;
            end
            auto_r    <= 1'b0;
            pending_r <= 1'b0;
        end else if (wr_fire_s && wr_ok_s) begin
            case (wr_idx_s)
                3'd0: begin
                    if (wstrb_r[0]) begin
                        auto_r <= wdata_r[1];
                        if (wdata_r[0]) begin
                            for (int k = 0; k < 4; k++) coef_r[k] <= shadow_r[k];
                            pending_r <= 1'b0;
                        end
                    end
                end
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    shadow_r[wr_sel_s] <= wr_merged_s;
                    // AUTO mirrors the shadow write straight into the active set
                    if (auto_r) coef_r[wr_sel_s] <= wr_merged_s;
                    else        pending_r        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FIR_SAMPLE_CNT_EN
    // Sample counter; a write to its address wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_r <= 32'd0;
        end else if (wr_fire_s && wr_ok_s && (wr_idx_s == 3'd6)) begin
            sample_cnt_r <= 32'd0;
        end else if (fir_valid_out) begin
            sample_cnt_r <= sample_cnt_r + 32'd1;
        end
    end
`endif

    // Read data mux; unmapped addresses read as zero
    always_comb begin
        rd_data_s = 32'd0;
        rd_idx_s  = s_axil_araddr[4:2];
        rd_sel_s  = rd_idx_s[1:0] - 2'd1;
        if (addr_ok(s_axil_araddr)) begin
            case (rd_idx_s)
                3'd0:                   rd_data_s = {30'd0, auto_r, 1'b0};
                3'd1, 3'd2, 3'd3, 3'd4: rd_data_s = {{(32-DATA_W){shadow_r[rd_sel_s][DATA_W-1]}}, shadow_r[rd_sel_s]};
                3'd5:                   rd_data_s = {31'd0, pending_r};
`ifdef FIR_SAMPLE_CNT_EN
                3'd6:                   rd_data_s = sample_cnt_r;
`endif
                default:                rd_data_s = 32'd0;
            endcase
        end else begin
            rd_data_s = 32'd0;
        end
    end

    // AR handshake and registered R response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            rresp_r  <= RESP_OKAY;
        end else if (s_axil_arvalid && !rvalid_r) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= addr_ok(s_axil_araddr) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_r && s_axil_rready) begin
            rvalid_r <= 1'b0;
        end
    end

    assign s_axil_awready = aw_ready_r;
    assign s_axil_wready  = w_ready_r;
    assign s_axil_bvalid  = bvalid_r;
    assign s_axil_bresp   = bresp_r;
    assign s_axil_arready = !rvalid_r;
    assign s_axil_rvalid  = rvalid_r;
    assign s_axil_rdata   = rdata_r;
    assign s_axil_rresp   = rresp_r;
    assign h0 = coef_r[0];
    assign h1 = coef_r[1];
    assign h2 = coef_r[2];
    assign h3 = coef_r[3];

`ifdef FIR_SAMPLE_CNT_EN
    assign unused_s = ^{s_axil_wdata[31:DATA_W], s_axil_wstrb[3:2], s_axil_awaddr[1:0], s_axil_araddr[1:0]};
`else
    assign unused_s = ^{s_axil_wdata[31:DATA_W], s_axil_wstrb[3:2], s_axil_awaddr[1:0], s_axil_araddr[1:0], fir_valid_out};
`endif

endmodule

// File: tb/tb_fir_coef_axil_regs.sv
// Directed bench for fir_coef_axil_regs with read/write response scoreboards.
module tb_fir_coef_axil_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = 8'h00, araddr = 8'h00;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        fir_valid_out = 1'b0;
    logic signed [15:0] h0, h1, h2, h3;

    int checks = 0;
    int failures = 0;
    logic [1:0]  wr_q [$];
    logic [33:0] rd_q [$];
    logic [15:0] h0_pre, h0_at_b, h1_at_b, h2_at_b, h3_at_b;

    fir_coef_axil_regs dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .fir_valid_out(fir_valid_out),
        .h0(h0), .h1(h1), .h2(h2), .h3(h3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input logic [1:0] exp_resp, input int bdelay);
        int cyc;
        int lat;
        bit w_started, aw_hs, w_hs;
        logic [1:0] exp_b;
        wr_q.push_back(exp_resp);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1;
        w_started = (lead == 0);
        wvalid = w_started;
        cyc = 0;
        while ((awvalid || wvalid || !w_started) && cyc < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            if (!w_started && cyc >= lead) begin
                check("aw_held_ready_low", {31'd0, awready}, 32'd0);
                wvalid = 1'b1;
                w_started = 1'b1;
            end
        end
        check("wr_handshake_bound", {31'd0, (cyc < 50)}, 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        h0_pre = h0;
        check("bvalid_early", {31'd0, bvalid}, 32'd0);
        lat = 0;
        while (!bvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b_latency", 32'(lat), 32'd1);
        h0_at_b = h0; h1_at_b = h1; h2_at_b = h2; h3_at_b = h3;
        for (int i = 0; i < bdelay; i++) begin
            @(posedge clk); #1;
            check("bvalid_hold", {31'd0, bvalid}, 32'd1);
            check("awready_hold_low", {31'd0, awready}, 32'd0);
        end
        exp_b = wr_q.pop_front();
        check($sformatf("bresp_%0h", addr), {30'd0, bresp}, {30'd0, exp_b});
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clear", {31'd0, bvalid}, 32'd0);
        check("aw_w_ready_back", {30'd0, awready, wready}, 32'd3);
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int lat;
        logic [33:0] exp_r;
        rd_q.push_back({exp_resp, exp_data});
        araddr = addr;
        arvalid = 1'b1;
        lat = 0;
        while (!arready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("r_latency", 32'(lat), 32'd0);
        exp_r = rd_q.pop_front();
        check($sformatf("rdata_%0h", addr), rdata, exp_r[31:0]);
        check($sformatf("rresp_%0h", addr), {30'd0, rresp}, {30'd0, exp_r[33:32]});
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_readies", {29'd0, awready, wready, arready}, 32'd7);
        check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_h", {h0, h1}, 32'h20002000);
        check("rst_h23", {h2, h3}, 32'h20002000);

        axi_read(8'h04, 32'h00002000, 2'b00);
        axi_read(8'h08, 32'h00002000, 2'b00);
        axi_read(8'h0C, 32'h00002000, 2'b00);
        axi_read(8'h10, 32'h00002000, 2'b00);
        axi_read(8'h14, 32'h00000000, 2'b00);
        axi_read(8'h00, 32'h00000000, 2'b00);

        // Shadow write with AW three cycles ahead of W
        axi_write(8'h04, 32'h00004000, 4'hF, 3, 2'b00, 0);
        check("h0_after_shadow", {16'd0, h0}, 32'h2000);
        axi_read(8'h14, 32'h00000001, 2'b00);
        axi_read(8'h04, 32'h00004000, 2'b00);

        // Commit
        axi_write(8'h00, 32'h00000001, 4'hF, 0, 2'b00, 0);
        check("h0_before_commit_edge", {16'd0, h0_pre}, 32'h2000);
        check("h0_at_commit", {16'd0, h0_at_b}, 32'h4000);
        axi_read(8'h14, 32'h00000000, 2'b00);
        axi_read(8'h00, 32'h00000000, 2'b00);

        // AUTO mode
        axi_write(8'h00, 32'h00000002, 4'hF, 0, 2'b00, 0);
        axi_write(8'h0C, 32'hFFFF8000, 4'h3, 0, 2'b00, 0);
        check("h2_auto", {16'd0, h2_at_b}, 32'h8000);
        axi_read(8'h0C, 32'hFFFF8000, 2'b00);
        axi_read(8'h14, 32'h00000000, 2'b00);
        axi_read(8'h00, 32'h00000002, 2'b00);

        // Byte strobes on a coefficient
        axi_write(8'h10, 32'h0000ABCD, 4'h1, 1, 2'b00, 0);
        check("h3_strb0", {16'd0, h3_at_b}, 32'h20CD);
        axi_read(8'h10, 32'h000020CD, 2'b00);
        axi_write(8'h10, 32'hAAAA7700, 4'hE, 0, 2'b00, 0);
        axi_read(8'h10, 32'h000077CD, 2'b00);

        // wstrb[0] gates CTRL
        axi_write(8'h00, 32'h00000000, 4'h0, 0, 2'b00, 0);
        axi_read(8'h00, 32'h00000002, 2'b00);
        axi_write(8'h00, 32'h00000000, 4'h1, 0, 2'b00, 0);
        axi_read(8'h00, 32'h00000000, 2'b00);

        // Shadow-then-commit with AUTO set in the same write
        axi_write(8'h08, 32'h00001234, 4'hF, 2, 2'b00, 0);
        check("h1_pending", {16'd0, h1_at_b}, 32'h2000);
        axi_read(8'h14, 32'h00000001, 2'b00);
        axi_write(8'h00, 32'h00000003, 4'hF, 0, 2'b00, 0);
        check("h1_commit", {16'd0, h1_at_b}, 32'h1234);
        axi_read(8'h14, 32'h00000000, 2'b00);
        axi_read(8'h00, 32'h00000002, 2'b00);

        // Decode errors
        axi_write(8'h1C, 32'h00005555, 4'hF, 0, 2'b10, 5);
        axi_write(8'h24, 32'h00001111, 4'hF, 0, 2'b10, 0);
        axi_read(8'h1C, 32'h00000000, 2'b10);
        axi_read(8'h24, 32'h00000000, 2'b10);
        axi_read(8'h04, 32'h00004000, 2'b00);
        check("h01_after_err", {h0, h1}, 32'h40001234);
        check("h23_after_err", {h2, h3}, 32'h800077CD);

`ifdef FIR_SAMPLE_CNT_EN
        fir_valid_out = 1'b1;
        repeat (7) @(posedge clk);
        #1 fir_valid_out = 1'b0;
        axi_read(8'h18, 32'd7, 2'b00);
        axi_write(8'h18, 32'h00000000, 4'hF, 0, 2'b00, 0);
        axi_read(8'h18, 32'd0, 2'b00);
`else
        axi_read(8'h18, 32'h00000000, 2'b10);
        axi_write(8'h18, 32'h00000000, 4'hF, 0, 2'b10, 0);
`endif

        // Reset in the middle of a write aborts it
        awaddr = 8'h04; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("mid_aw_captured", {31'd0, awready}, 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_ready", {31'd0, awready}, 32'd1);
        check("async_rst_h0", {16'd0, h0}, 32'h2000);
        @(posedge clk); #1 rst = 1'b0;
        wdata = 32'h00007777; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1 wvalid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_b_after_rst", {31'd0, bvalid}, 32'd0);
        end
        check("h0_after_abort", {16'd0, h0}, 32'h2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
